// File: rtl/ws2812_serializer.sv
// WS2812 frame serializer: fetches GRB pixels from frame memory and drives the
// single-wire NRZ line, prefetching the next pixel so pixels follow without gaps.
module ws2812_serializer #(
  parameter int unsigned T0H_CYCLES   = 20,
  parameter int unsigned T1H_CYCLES   = 40,
  parameter int unsigned BIT_CYCLES   = 63,
  parameter int unsigned RESET_CYCLES = 4000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] num_leds,
  output logic        rd_en,
  output logic [11:0] rd_addr,
  input  logic [23:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        data
);

  localparam int unsigned PW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned LW = $clog2(RESET_CYCLES + 1);
  localparam logic [PW-1:0] PH_LAST    = PW'(BIT_CYCLES - 1);
  localparam logic [PW-1:0] PH_T0      = PW'(T0H_CYCLES);
  localparam logic [PW-1:0] PH_T1      = PW'(T1H_CYCLES);
  localparam logic [LW-1:0] LATCH_LAST = LW'(RESET_CYCLES);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, SEND, LATCH} state_t;
  state_t state, state_d;

  logic [11:0]   n_last;
  logic [11:0]   pix;
  logic [4:0]    bit_idx;
  logic [PW-1:0] phase;
  logic [LW-1:0] lcnt;
  logic [23:0]   shift;
  logic [23:0]   next_px;
  logic          fill;
  logic          bit_end, frame_end, prefetch, latch_end;

  always_comb begin
    bit_end   = (phase == PH_LAST);
    frame_end = bit_end && (bit_idx == 5'd0) && (pix == n_last);
    prefetch  = (state == SEND) && (phase == '0) && (bit_idx == 5'd23) && (pix != n_last);
    latch_end = (lcnt == LATCH_LAST);
    state_d   = state;
    unique case (state)
      IDLE:    if (start && (num_leds != '0)) state_d = FETCH;
      FETCH:   state_d = WAIT;
      WAIT:    state_d = SEND;
      SEND:    if (frame_end) state_d = LATCH;
      LATCH:   if (latch_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // data is registered from the SEND state, so the wire lags the phase counter
  // by one cycle; LATCH runs one extra state cycle to give RESET_CYCLES of low line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      data    <= 1'b0;
      n_last  <= '0;
      pix     <= '0;
      bit_idx <= '0;
      phase   <= '0;
      lcnt    <= '0;
      shift   <= '0;
      next_px <= '0;
      fill    <= 1'b0;
    end else begin
      rd_en <= 1'b0;
      done  <= 1'b0;
      fill  <= rd_en && (state == SEND);
      if (fill) next_px <= rd_data;
      data <= (state == SEND) && (phase < (shift[23] ? PH_T1 : PH_T0));
      unique case (state)
        IDLE: begin
          if (start) begin
            n_last <= num_leds - 12'd1;
            if (num_leds == '0) begin
              done <= 1'b1;
            end else begin
              rd_en   <= 1'b1;
              rd_addr <= '0;
              busy    <= 1'b1;
            end
          end
        end
        WAIT: begin
          shift   <= rd_data;
          bit_idx <= 5'd23;
          pix     <= '0;
          phase   <= '0;
        end
        SEND: begin
          lcnt <= '0;
          if (prefetch) begin
            rd_en   <= 1'b1;
            rd_addr <= pix + 12'd1;
          end
          if (bit_end) begin
            phase <= '0;
            if (bit_idx == 5'd0) begin
              bit_idx <= 5'd23;
              shift   <= next_px;
              pix     <= pix + 12'd1;
            end else begin
              bit_idx <= bit_idx - 5'd1;
              shift   <= {shift[22:0], 1'b0};
            end
          end else begin
            phase <= phase + PW'(1);
          end
        end
        LATCH: begin
          if (latch_end) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            lcnt <= lcnt + LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
